// File: rtl/anton_neopixel_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | anton_neopixel_sequencer_if                                              |
// | Control and timing-index bundle between the register block, the frame    |
// | sequencer and the downstream stream stage.                               |
// |                                                                          |
// | master : register/control side (drives controls, observes indices)       |
// |   regCtrlRun, regCtrlLoop, regCtrl32bit, regMax  -> sequencer            |
// |   state, pixelIndex, channelIndex, pixelBitIndex, bitPatternIndex,       |
// |   frameDone                                      <- sequencer            |
// | slave  : sequencer side (mirror of master)                               |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface anton_neopixel_sequencer_if #(
   parameter int BUFFER_END = 12
);
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);

   logic                   regCtrlRun;
   logic                   regCtrlLoop;
   logic                   regCtrl32bit;
   logic [BUFFER_BITS-1:0] regMax;
   logic                   state;
   logic [BUFFER_BITS-1:0] pixelIndex;
   logic [1:0]             channelIndex;
   logic [2:0]             pixelBitIndex;
   logic [2:0]             bitPatternIndex;
   logic                   frameDone;

   modport master (
      output regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
      input  state, pixelIndex, channelIndex, pixelBitIndex, bitPatternIndex, frameDone
   );

   modport slave (
      input  regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
      output state, pixelIndex, channelIndex, pixelBitIndex, bitPatternIndex, frameDone
   );
endinterface
`default_nettype wire

// File: rtl/anton_neopixel_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | anton_neopixel_sequencer                                                 |
// | Frame state machine and nested bit/channel/pixel counters for the        |
// | NeoPixel transmit path. Every frame is preceded by a line-low latch      |
// | interval and followed by another one that ends with a frameDone pulse.   |
// |                                                                          |
// | Ports:                                                                   |
// |   clk7mhz : single clock, rising edge                                    |
// |   resetn  : asynchronous active-low reset                                |
// |   seq     : slave side of anton_neopixel_sequencer_if                    |
// |             (run/loop/32-bit/regMax in; state, indices, frameDone out)   |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module anton_neopixel_sequencer #(
   parameter int BUFFER_END   = 12,
   parameter int RESET_CYCLES = 400
) (
   input  logic                      clk7mhz,
   input  logic                      resetn,
   anton_neopixel_sequencer_if.slave seq
);
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
   localparam int LATCH_BITS  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [LATCH_BITS-1:0]  LATCH_LAST     = LATCH_BITS'(RESET_CYCLES - 1);
   localparam logic [BUFFER_BITS-1:0] BUFFER_END_IDX = BUFFER_BITS'(BUFFER_END);
   localparam logic STATE_RESET    = 1'b0;
   localparam logic STATE_TRANSMIT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_TX    = 2'd2
   } fsm_t;

   fsm_t                   r_fsm,   w_fsm_nxt;
   logic                   r_first, w_first_nxt;
   logic [LATCH_BITS-1:0]  r_latch, w_latch_nxt;
   logic [BUFFER_BITS-1:0] r_pix,   w_pix_nxt;
   logic [1:0]             r_chan,  w_chan_nxt;
   logic [2:0]             r_bit,   w_bit_nxt;
   logic [2:0]             r_pat,   w_pat_nxt;
   logic                   r_done,  w_done_nxt;
   logic                   r_run_q;
   logic                   r_run_armed;
   logic                   w_run_rise;
   logic [BUFFER_BITS-1:0] w_eff_max;
   logic [BUFFER_BITS-1:0] w_step;
   logic                   w_last_pixel;

   // The run-edge register only becomes meaningful one clock after reset, so
   // a run bit that was already high across reset is not taken as a new edge.
   assign w_run_rise = seq.regCtrlRun & ~r_run_q & r_run_armed;

   assign w_eff_max = (seq.regMax > BUFFER_END_IDX) ? BUFFER_END_IDX : seq.regMax;
   assign w_step    = seq.regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);

   // In 32-bit mode the low two index bits are the channel/padding byte.
   assign w_last_pixel = seq.regCtrl32bit
                       ? (r_pix[BUFFER_BITS-1:2] == w_eff_max[BUFFER_BITS-1:2])
                       : (r_pix == w_eff_max);

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_first_nxt = r_first;
      w_latch_nxt = r_latch;
      w_pix_nxt   = r_pix;
      w_chan_nxt  = r_chan;
      w_bit_nxt   = r_bit;
      w_pat_nxt   = r_pat;

      if (!seq.regCtrlRun) begin
         w_fsm_nxt   = ST_IDLE;
         w_first_nxt = 1'b0;
         w_latch_nxt = '0;
         w_pix_nxt   = '0;
         w_chan_nxt  = '0;
         w_bit_nxt   = '0;
         w_pat_nxt   = '0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (w_run_rise) begin
                  w_fsm_nxt   = ST_LATCH;
                  w_first_nxt = 1'b1;
                  w_latch_nxt = '0;
               end
            end
            ST_LATCH: begin
               if (r_latch == LATCH_LAST) begin
                  w_latch_nxt = '0;
                  // The leading latch always proceeds to a frame; a trailing
                  // one only does so in loop mode.
                  if (r_first || seq.regCtrlLoop) begin
                     w_fsm_nxt   = ST_TX;
                     w_first_nxt = 1'b0;
                  end else begin
                     w_fsm_nxt = ST_IDLE;
                  end
               end else begin
                  w_latch_nxt = r_latch + LATCH_BITS'(1);
               end
            end
            ST_TX: begin
               w_pat_nxt = r_pat + 3'd1;
               if (r_pat == 3'd7) begin
                  w_bit_nxt = r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     if (r_chan == 2'd2) begin
                        w_chan_nxt = 2'd0;
                        if (w_last_pixel) begin
                           w_fsm_nxt   = ST_LATCH;
                           w_pix_nxt   = '0;
                           w_latch_nxt = '0;
                        end else begin
                           w_pix_nxt = r_pix + w_step;
                        end
                     end else begin
                        w_chan_nxt = r_chan + 2'd1;
                     end
                  end
               end
            end
            default: begin
               w_fsm_nxt = ST_IDLE;
            end
         endcase
      end

      // Registered pulse marks the final latch count as it is entered.
      w_done_nxt = (w_fsm_nxt == ST_LATCH) && (w_latch_nxt == LATCH_LAST);
   end

   always_ff @(posedge clk7mhz or negedge resetn) begin
      if (!resetn) begin
         r_fsm       <= ST_IDLE;
         r_first     <= 1'b0;
         r_latch     <= '0;
         r_pix       <= '0;
         r_chan      <= '0;
         r_bit       <= '0;
         r_pat       <= '0;
         r_done      <= 1'b0;
         r_run_q     <= 1'b0;
         r_run_armed <= 1'b0;
      end else begin
         r_fsm       <= w_fsm_nxt;
         r_first     <= w_first_nxt;
         r_latch     <= w_latch_nxt;
         r_pix       <= w_pix_nxt;
         r_chan      <= w_chan_nxt;
         r_bit       <= w_bit_nxt;
         r_pat       <= w_pat_nxt;
         r_done      <= w_done_nxt;
         r_run_q     <= seq.regCtrlRun;
         r_run_armed <= 1'b1;
      end
   end

   assign seq.state           = (r_fsm == ST_TX) ? STATE_TRANSMIT : STATE_RESET;
   assign seq.pixelIndex      = r_pix;
   assign seq.channelIndex    = r_chan;
   assign seq.pixelBitIndex   = r_bit;
   assign seq.bitPatternIndex = r_pat;
   assign seq.frameDone       = r_done;
endmodule
`default_nettype wire
